fp16_normalize_round: RTL and testbench



---
 rtl/fp16_normalize_round_pkg.sv | 10 +
 rtl/fp16_normalize_round_if.sv | 27 ++
 rtl/fp16_normalize_round_rne.sv | 50 +++++
 rtl/fp16_normalize_round.sv | 98 +++++++++
 tb/tb_fp16_normalize_round.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/fp16_normalize_round_pkg.sv
// Shared definitions for the half-precision post-adder normalize/round stage.
package fp16_pkg;
  localparam int EXP_W   = 5;
  localparam int FRAC_W  = 10;
  localparam int MANT_W  = FRAC_W + 3;
  localparam int EXP_INF = 31;
  localparam int BIAS    = 15;

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;
endpackage

// File: rtl/fp16_normalize_round_if.sv
// Valid/ready bundle between the add/sub unit, the normalizer and its consumer.
interface fp16_normalize_round_if #(
  parameter int EXP_W  = 5,
  parameter int FRAC_W = 10
);
  logic                      in_valid;
  logic                      in_ready;
  logic                      in_sign;
  logic [EXP_W-1:0]          in_exp;
  logic [FRAC_W+2:0]         in_mant;
  logic                      in_sticky;
  logic                      out_valid;
  logic                      out_ready;
  logic [EXP_W+FRAC_W:0]     out_result;
  logic                      out_overflow;
  logic                      out_underflow;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, in_sticky, out_ready,
    input  in_ready, out_valid, out_result, out_overflow, out_underflow
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, in_sticky, out_ready,
    output in_ready, out_valid, out_result, out_overflow, out_underflow
  );
endinterface

// File: rtl/fp16_normalize_round_rne.sv
// Round-to-nearest-even and IEEE packing of a normalized (or subnormal) mantissa.
module fp16_round_rne #(
  parameter int EXP_W  = 5,
  parameter int FRAC_W = 10
) (
  input  logic [FRAC_W+1:0]    mant,
  input  logic                 sticky,
  input  logic [EXP_W:0]       exp,
  input  logic                 sign,
  output logic [EXP_W+FRAC_W:0] result,
  output logic                 overflow,
  output logic                 underflow
);
  localparam logic [EXP_W:0] EXP_ONE = 1;
  localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

  logic                inc;
  logic [FRAC_W+1:0]   r;
  logic [FRAC_W-1:0]   frac;
  logic                hidden;
  logic [EXP_W:0]      exp_n;
  logic [EXP_W-1:0]    exp_f;

  always_comb begin
    inc    = mant[0] & (sticky | mant[1]);
    r      = {1'b0, mant[FRAC_W+1:1]} + {{(FRAC_W+1){1'b0}}, inc};
    frac   = r[FRAC_W-1:0];
    hidden = r[FRAC_W];
    exp_n  = exp;
    // Mantissa rounded up to 2.0: renormalize by bumping the exponent.
    if (r[FRAC_W+1]) begin
      frac   = '0;
      hidden = 1'b1;
      exp_n  = exp + EXP_ONE;
    end
    exp_f     = hidden ? exp_n[EXP_W-1:0] : '0;
    overflow  = 1'b0;
    underflow = 1'b0;
    if (mant == '0) begin
      result    = '0;
      underflow = 1'b1;
    end else if (exp_n >= EXP_MAX) begin
      result   = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      overflow = 1'b1;
    end else begin
      result    = {sign, exp_f, frac};
      underflow = (exp_f == '0) && (frac != '0);
    end
  end
endmodule

// File: rtl/fp16_normalize_round.sv
// Iterative one-bit-per-cycle normalizer feeding an RNE rounder; one result in flight.
module fp16_normalize_round #(
  parameter int EXP_W  = 5,
  parameter int FRAC_W = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  fp16_normalize_round_if.slave bus
);
  import fp16_pkg::*;

  localparam int             MANT_N  = FRAC_W + 3;
  localparam logic [EXP_W:0] EXP_ONE = 1;

  state_t                state_q, state_d;
  logic [MANT_N-1:0]     mant_q, mant_d;
  logic [EXP_W:0]        exp_q, exp_d;
  logic                  sticky_q, sticky_d;
  logic                  sign_q, sign_d;
  logic [EXP_W+FRAC_W:0] res_q, rnd_result;
  logic                  ovf_q, unf_q, rnd_ovf, rnd_unf;

  always_comb begin
    state_d  = state_q;
    mant_d   = mant_q;
    exp_d    = exp_q;
    sticky_d = sticky_q;
    sign_d   = sign_q;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        mant_d   = bus.in_mant;
        exp_d    = {1'b0, bus.in_exp};
        sticky_d = bus.in_sticky;
        sign_d   = bus.in_sign;
        state_d  = NORM;
      end
      NORM: begin
        if (mant_q == '0) begin
          state_d = ROUND;
        end else if (mant_q[MANT_N-1]) begin
          mant_d   = mant_q >> 1;
          sticky_d = sticky_q | mant_q[0];
          exp_d    = exp_q + EXP_ONE;
          state_d  = ROUND;
        end else if (mant_q[MANT_N-2] || exp_q == EXP_ONE) begin
          // exp==1 stops shifting: the value stays subnormal.
          state_d = ROUND;
        end else begin
          mant_d = mant_q << 1;
          exp_d  = exp_q - EXP_ONE;
        end
      end
      ROUND:   state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  fp16_round_rne #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_rne (
    .mant      (mant_q[MANT_N-2:0]),
    .sticky    (sticky_q),
    .exp       (exp_q),
    .sign      (sign_q),
    .result    (rnd_result),
    .overflow  (rnd_ovf),
    .underflow (rnd_unf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mant_q   <= '0;
      exp_q    <= '0;
      sticky_q <= 1'b0;
      sign_q   <= 1'b0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mant_q   <= mant_d;
      exp_q    <= exp_d;
      sticky_q <= sticky_d;
      sign_q   <= sign_d;
      if (state_q == ROUND) begin
        res_q <= rnd_result;
        ovf_q <= rnd_ovf;
        unf_q <= rnd_unf;
      end
    end
  end

  assign bus.in_ready      = (state_q == IDLE);
  assign bus.out_valid     = (state_q == DONE);
  assign bus.out_result    = res_q;
  assign bus.out_overflow  = ovf_q;
  assign bus.out_underflow = unf_q;
endmodule

// File: tb/tb_fp16_normalize_round.sv
// Vector table plus scoreboard bench for fp16_normalize_round.
module tb_fp16_normalize_round;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp16_normalize_round_if bus ();

  fp16_normalize_round dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic        sign;
    logic [4:0]  exp;
    logic [12:0] mant;
    logic        sticky;
    logic [15:0] res;
    logic        ovf;
    logic        unf;
    int          k;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    logic        ovf;
    logic        unf;
  } exp_t;

  localparam int NV = 17;
  vec_t vt [NV];
  exp_t sb [$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Latency counts rising edges from (and including) the accepting edge.
  task automatic send(input vec_t v);
    int t = 0;
    int lat;
    while (!bus.in_ready && t < 50) begin
      @(posedge clk); #1; t++;
    end
    chk("in_ready_before_send", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid  = 1'b1;
    bus.in_sign   = v.sign;
    bus.in_exp    = v.exp;
    bus.in_mant   = v.mant;
    bus.in_sticky = v.sticky;
    sb.push_back('{v.res, v.ovf, v.unf});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    chk("latency", lat, 3 + v.k);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL scoreboard_empty: got output 0x%0h, expected none", bus.out_result);
    end else begin
      e = sb.pop_front();
      chk("result", {16'd0, bus.out_result}, {16'd0, e.res});
      chk("overflow", {31'd0, bus.out_overflow}, {31'd0, e.ovf});
      chk("underflow", {31'd0, bus.out_underflow}, {31'd0, e.unf});
    end
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("out_valid_drop", {31'd0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic [15:0] held;
    logic seen;
    //       sign exp    mant      st  result    ovf unf k
    vt[0]  = '{0, 5'd15, 13'h0800, 0, 16'h3C00, 0, 0, 0};
    vt[1]  = '{0, 5'd15, 13'h1000, 0, 16'h4000, 0, 0, 0};
    vt[2]  = '{0, 5'd30, 13'h1000, 0, 16'h7C00, 1, 0, 0};
    vt[3]  = '{0, 5'd15, 13'h0100, 0, 16'h3000, 0, 0, 3};
    vt[4]  = '{0, 5'd1,  13'h0400, 0, 16'h0200, 0, 1, 0};
    vt[5]  = '{0, 5'd15, 13'h0801, 0, 16'h3C00, 0, 0, 0};
    vt[6]  = '{0, 5'd15, 13'h0803, 0, 16'h3C02, 0, 0, 0};
    vt[7]  = '{0, 5'd15, 13'h0801, 1, 16'h3C01, 0, 0, 0};
    vt[8]  = '{0, 5'd15, 13'h0FFF, 0, 16'h4000, 0, 0, 0};
    vt[9]  = '{1, 5'd20, 13'h0000, 0, 16'h0000, 0, 1, 0};
    vt[10] = '{1, 5'd15, 13'h0800, 0, 16'hBC00, 0, 0, 0};
    vt[11] = '{0, 5'd3,  13'h0100, 0, 16'h0200, 0, 1, 2};
    vt[12] = '{0, 5'd15, 13'h1003, 0, 16'h4001, 0, 0, 0};
    vt[13] = '{0, 5'd30, 13'h0FFF, 0, 16'h7C00, 1, 0, 0};
    vt[14] = '{0, 5'd1,  13'h07FF, 0, 16'h0400, 0, 0, 0};
    vt[15] = '{0, 5'd20, 13'h0001, 0, 16'h2400, 0, 0, 11};
    vt[16] = '{1, 5'd30, 13'h1000, 0, 16'hFC00, 1, 0, 0};

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_sign = 1'b0; bus.in_exp = '0;
    bus.in_mant = '0; bus.in_sticky = 1'b0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_result", {16'd0, bus.out_result}, 32'd0);
    chk("rst_flags", {30'd0, bus.out_overflow, bus.out_underflow}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      send(vt[i]);
      check_out();
      release_out();
    end

    // Back-pressure: result and flags hold while new requests are ignored.
    bus.out_ready = 1'b0;
    v = vt[7];
    send(v);
    held = bus.out_result;
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = 1'b1;
      bus.in_exp   = 5'd10;
      bus.in_mant  = 13'($urandom_range(1, 8191));
      @(posedge clk); #1;
      chk("hold_result", {16'd0, bus.out_result}, {16'd0, v.res});
      chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.in_valid = 1'b0;
    chk("hold_first_sample", {16'd0, held}, {16'd0, v.res});
    check_out();
    release_out();
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1; seen |= bus.out_valid;
    end
    chk("no_output_from_ignored_req", {31'd0, seen}, 32'd0);

    // Reset while normalizing discards the operation and clears outputs.
    bus.in_valid = 1'b1; bus.in_sign = 1'b1; bus.in_exp = 5'd15;
    bus.in_mant = 13'h0001; bus.in_sticky = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("abort_out_result", {16'd0, bus.out_result}, 32'd0);
    chk("abort_flags", {30'd0, bus.out_overflow, bus.out_underflow}, 32'd0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1; seen |= bus.out_valid;
    end
    chk("no_output_after_abort", {31'd0, seen}, 32'd0);

    send(vt[6]);
    check_out();
    release_out();
    chk("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
